// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V opcodes, funct3 codes,
// the zero word and data-bus request levels.
package mem_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_R     = 7'b0110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam logic BUS_REQ  = 1'b1;
    localparam logic BUS_IDLE = 1'b0;

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational lane selection, byte enables, store replication and
// load extension. MEM_MISALIGN_CHK_EN turns misaligned half/word accesses into errors.
module mem_align
    import mem_lsu_pkg::*;
#(
    parameter  int DW = 32,
    localparam int BW = DW / 8,
    localparam int OW = $clog2(BW)
) (
    input  logic [2:0]    funct3,
    input  logic          is_store,
    input  logic [OW-1:0] offset,
    input  logic [31:0]   store_data,
    input  logic [DW-1:0] rdata,
    output logic [BW-1:0] be,
    output logic [DW-1:0] wdata,
    output logic [31:0]   load_data,
    output logic          bad_funct3,
    output logic          misaligned
);

    localparam logic [OW-1:0] HALF_MASK = ~OW'(1);
    localparam logic [OW-1:0] WORD_MASK = ~OW'(3);

    logic [OW-1:0] lane;
    logic [31:0]   lane_word;

    // Half and word accesses snap down to their natural boundary.
    always_comb begin
        case (funct3[1:0])
            2'b00:   lane = offset;
            2'b01:   lane = offset & HALF_MASK;
            default: lane = offset & WORD_MASK;
        endcase
    end

    assign lane_word = 32'(rdata >> {lane, 3'b000});

    always_comb begin
        be        = '0;
        wdata     = '0;
        load_data = ZERO_WORD;
        case (funct3[1:0])
            2'b00: begin
                be    = BW'(1) << lane;
                wdata = {BW{store_data[7:0]}};
            end
            2'b01: begin
                be    = BW'(3) << lane;
                wdata = {(BW / 2){store_data[15:0]}};
            end
            default: begin
                be    = BW'(15) << lane;
                wdata = {(BW / 4){store_data}};
            end
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            F3_LH:   load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            F3_LW:   load_data = lane_word;
            F3_LBU:  load_data = {24'h0, lane_word[7:0]};
            F3_LHU:  load_data = {16'h0, lane_word[15:0]};
            default: load_data = ZERO_WORD;
        endcase
    end

    always_comb begin
        if (is_store) begin
            bad_funct3 = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
        end else begin
            bad_funct3 = !(funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                           funct3 == F3_LBU || funct3 == F3_LHU);
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign misaligned = !bad_funct3 && (lane != offset);
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage; passes ALU results through and runs loads/stores over
// a req/gnt/rvalid data-RAM bus with timeout. Optional MEM_MISALIGN_CHK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               valid_i,
    input  logic [31:0]        inst_i,
    input  logic [AW-1:0]      instaddr_i,
    input  logic               regs_wen_i,
    input  logic [4:0]         rd_addr_i,
    input  logic [31:0]        rd_data_i,
    input  logic [AW-1:0]      mem_addr_i,
    input  logic [31:0]        store_data_i,
    output logic               stall_o,
    output logic               req_o,
    output logic               we_o,
    output logic [AW-1:0]      addr_o,
    output logic [DW/8-1:0]    be_o,
    output logic [DW-1:0]      wdata_o,
    input  logic               gnt_i,
    input  logic               rvalid_i,
    input  logic [DW-1:0]      rdata_i,
    output logic               valid_o,
    output logic [31:0]        inst_o,
    output logic [AW-1:0]      instaddr_o,
    output logic               regs_wen_o,
    output logic [4:0]         rd_addr_o,
    output logic [31:0]        rd_data_o,
    output logic               err_o
);

    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t        state;
    logic [31:0]   inst_q;
    logic [AW-1:0] instaddr_q;
    logic          regs_wen_q;
    logic [4:0]    rd_addr_q;
    logic [31:0]   rd_data_q;
    logic [2:0]    funct3_q;
    logic [OW-1:0] offset_q;
    logic          is_store_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [BW-1:0] be_q;
    logic [DW-1:0] wdata_q;

    logic          is_load_in;
    logic          is_store_in;
    logic          is_ls_in;
    logic          timeout;
    logic [2:0]    funct3_sel;
    logic [OW-1:0] offset_sel;
    logic          is_store_sel;
    logic [BW-1:0] be_c;
    logic [DW-1:0] wdata_c;
    logic [31:0]   load_c;
    logic          bad_c;
    logic          misal_c;

    assign is_load_in  = inst_i[6:0] == OPC_LOAD;
    assign is_store_in = inst_i[6:0] == OPC_STORE;
    assign is_ls_in    = is_load_in || is_store_in;
    assign timeout     = cnt_q == CW'(TIMEOUT_CYC - 1);

    // The aligner sees the live instruction while deciding to accept, and the
    // captured one afterwards so load extraction is independent of ex_mem.
    assign funct3_sel   = (state == S_IDLE) ? inst_i[14:12]          : funct3_q;
    assign offset_sel   = (state == S_IDLE) ? mem_addr_i[OW-1:0]     : offset_q;
    assign is_store_sel = (state == S_IDLE) ? is_store_in            : is_store_q;

    mem_align #(.DW(DW)) u_align (
        .funct3     (funct3_sel),
        .is_store   (is_store_sel),
        .offset     (offset_sel),
        .store_data (store_data_i),
        .rdata      (rdata_i),
        .be         (be_c),
        .wdata      (wdata_c),
        .load_data  (load_c),
        .bad_funct3 (bad_c),
        .misaligned (misal_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            inst_q     <= ZERO_WORD;
            instaddr_q <= '0;
            regs_wen_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= ZERO_WORD;
            funct3_q   <= '0;
            offset_q   <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            req_q      <= BUS_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i && is_ls_in) begin
                        inst_q     <= inst_i;
                        instaddr_q <= instaddr_i;
                        regs_wen_q <= regs_wen_i;
                        rd_addr_q  <= rd_addr_i;
                        rd_data_q  <= ZERO_WORD;
                        funct3_q   <= inst_i[14:12];
                        offset_q   <= mem_addr_i[OW-1:0];
                        is_store_q <= is_store_in;
                        cnt_q      <= '0;
                        if (bad_c || misal_c) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            req_q   <= BUS_REQ;
                            we_q    <= is_store_in;
                            addr_q  <= {mem_addr_i[AW-1:OW], {OW{1'b0}}};
                            be_q    <= be_c;
                            wdata_q <= wdata_c;
                            state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (timeout) begin
                        req_q <= BUS_IDLE;
                        we_q  <= 1'b0;
                        be_q  <= '0;
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        if (gnt_i) begin
                            req_q <= BUS_IDLE;
                            we_q  <= 1'b0;
                            be_q  <= '0;
                            state <= S_WAIT;
                        end
                    end
                end
                // A response arriving in the final allowed cycle still completes.
                S_WAIT: begin
                    if (rvalid_i) begin
                        rd_data_q <= is_store_q ? ZERO_WORD : load_c;
                        state     <= S_DONE;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign be_o    = be_q;
    assign wdata_o = wdata_q;

    always_comb begin
        valid_o    = 1'b0;
        stall_o    = 1'b0;
        err_o      = 1'b0;
        inst_o     = inst_q;
        instaddr_o = instaddr_q;
        regs_wen_o = 1'b0;
        rd_addr_o  = rd_addr_q;
        rd_data_o  = ZERO_WORD;
        case (state)
            S_IDLE: begin
                valid_o    = valid_i && !is_ls_in;
                stall_o    = valid_i && is_ls_in;
                inst_o     = inst_i;
                instaddr_o = instaddr_i;
                regs_wen_o = regs_wen_i;
                rd_addr_o  = rd_addr_i;
                rd_data_o  = rd_data_i;
            end
            S_REQ, S_WAIT: stall_o = 1'b1;
            S_DONE: begin
                valid_o    = 1'b1;
                err_o      = err_q;
                regs_wen_o = regs_wen_q && !is_store_q && !err_q;
                rd_data_o  = rd_data_q;
            end
            default: ;
        endcase
        // Handshake outputs must be quiet the instant reset is asserted.
        if (!rstn) begin
            valid_o = 1'b0;
            stall_o = 1'b0;
            err_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu (DW=64): directed scenarios plus randomized
// loads/stores compared against a byte-level reference model.
module tb_mem_lsu;

    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int TMO = 16;
    localparam int BW  = DW / 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          valid_i = 1'b0;
    logic [31:0]   inst_i = '0;
    logic [AW-1:0] instaddr_i = '0;
    logic          regs_wen_i = 1'b0;
    logic [4:0]    rd_addr_i = '0;
    logic [31:0]   rd_data_i = '0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [31:0]   store_data_i = '0;
    logic          gnt_i = 1'b0;
    logic          rvalid_i = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic          stall_o, req_o, we_o, valid_o, regs_wen_o, err_o;
    logic [AW-1:0] addr_o, instaddr_o;
    logic [BW-1:0] be_o;
    logic [DW-1:0] wdata_o;
    logic [31:0]   inst_o, rd_data_o;
    logic [4:0]    rd_addr_o;

    int total = 0;
    int bad   = 0;

    mem_lsu #(.DW(DW), .AW(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .inst_i(inst_i),
        .instaddr_i(instaddr_i), .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i),
        .rd_data_i(rd_data_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o),
        .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o),
        .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0A5C3, f3, rd, opc};
    endfunction

    function automatic logic [AW-1:0] iaddr_of(input logic [AW-1:0] maddr);
        return maddr ^ 32'h5A5A_0000;
    endfunction

    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte position of the access inside the bus word, rounded down to its size.
    function automatic int lane_of(input logic [2:0] f3, input logic [AW-1:0] addr);
        int off;
        off = int'(addr % BW);
        return off - (off % access_size(f3));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [AW-1:0] addr, input logic [DW-1:0] rdata);
        int sz, ln;
        logic [31:0] val;
        sz  = access_size(f3);
        ln  = lane_of(f3, addr);
        val = '0;
        for (int i = 0; i < sz; i++) val[8*i +: 8] = rdata[8*(ln+i) +: 8];
        if (!f3[2] && sz < 4 && val[8*sz-1]) begin
            for (int i = sz; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end
        return val;
    endfunction

    function automatic logic [BW-1:0] model_be(input logic [2:0] f3, input logic [AW-1:0] addr);
        logic [BW-1:0] m;
        m = '0;
        for (int i = 0; i < access_size(f3); i++) m[lane_of(f3, addr) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [DW-1:0] model_wdata(input logic [2:0] f3, input logic [31:0] sdata);
        logic [DW-1:0] w;
        for (int i = 0; i < BW; i++) w[8*i +: 8] = sdata[8*(i % access_size(f3)) +: 8];
        return w;
    endfunction

    function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [AW-1:0] addr);
        logic e;
        int off;
        off = int'(addr % BW);
        e = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
`ifdef MEM_MISALIGN_CHK_EN
        if (!e && (off % access_size(f3)) != 0) e = 1'b1;
`else
        if (off < 0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [AW-1:0] maddr,
                                 input logic [31:0] sdata, input logic wen, input logic [4:0] rda,
                                 input logic [31:0] rdat);
        valid_i      = v;
        inst_i       = inst;
        mem_addr_i   = maddr;
        instaddr_i   = iaddr_of(maddr);
        store_data_i = sdata;
        regs_wen_i   = wen;
        rd_addr_i    = rda;
        rd_data_i    = rdat;
    endtask

    task automatic do_pass(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] rdat, input logic wen, input logic [4:0] rda);
        applyStimulus(v, inst, 32'h0000_0040, 32'h0, wen, rda, rdat);
        #1;
        checkOutput({tag, ".valid"}, valid_o, v);
        checkOutput({tag, ".stall"}, stall_o, 0);
        checkOutput({tag, ".rd_data"}, rd_data_o, rdat);
        checkOutput({tag, ".inst"}, inst_o, inst);
        checkOutput({tag, ".wen"}, regs_wen_o, wen);
        checkOutput({tag, ".rd_addr"}, rd_addr_o, rda);
        checkOutput({tag, ".err"}, err_o, 0);
        @(negedge clk);
    endtask

    // One load/store: gnt_i after gd idle REQ cycles, rvalid_i after rd idle WAIT cycles.
    task automatic do_access(input string tag, input logic [31:0] inst, input logic [AW-1:0] maddr,
                             input logic [31:0] sdata, input logic [DW-1:0] rdata, input logic wen,
                             input logic [4:0] rda, input int gd, input int rd, output int lat);
        logic st, err_imm, timed_out, err_exp, wen_exp;
        logic [2:0] f3;
        logic [31:0] rd_exp;
        int n, k, phase;
        st      = inst[6:0] == 7'b0100011;
        f3      = inst[14:12];
        err_imm = model_err(st, f3, maddr);
        applyStimulus(1'b1, inst, maddr, sdata, wen, rda, 32'hDEAD_0000);
        gnt_i = 1'b0;
        rvalid_i = 1'b0;
        #1;
        checkOutput({tag, ".acc_stall"}, stall_o, 1);
        checkOutput({tag, ".acc_valid"}, valid_o, 0);
        @(negedge clk);
        lat = 1;
        timed_out = 1'b0;
        n = 0;
        k = 0;
        phase = err_imm ? 2 : 0;
        while (phase < 2) begin
            n++;
            if (phase == 0) begin
                gnt_i    = (k == gd);
                rvalid_i = 1'($urandom_range(0, 1));
                rdata_i  = {$urandom(), $urandom()};
                #1;
                checkOutput({tag, ".req"}, req_o, 1);
                checkOutput({tag, ".stall_req"}, stall_o, 1);
                checkOutput({tag, ".addr"}, addr_o, maddr & ~AW'(BW - 1));
                checkOutput({tag, ".we"}, we_o, st);
                if (st) begin
                    checkOutput({tag, ".be"}, be_o, model_be(f3, maddr));
                    checkOutput({tag, ".wdata"}, wdata_o, model_wdata(f3, sdata));
                end
                if (n == TMO) begin
                    timed_out = 1'b1;
                    phase = 2;
                end else if (k == gd) begin
                    phase = 1;
                    k = 0;
                end else begin
                    k++;
                end
            end else begin
                gnt_i    = 1'b0;
                rvalid_i = (k == rd);
                rdata_i  = (k == rd) ? rdata : {$urandom(), $urandom()};
                #1;
                checkOutput({tag, ".req_wait"}, req_o, 0);
                checkOutput({tag, ".stall_wait"}, stall_o, 1);
                checkOutput({tag, ".valid_wait"}, valid_o, 0);
                if (k == rd) phase = 2;
                else if (n == TMO) begin
                    timed_out = 1'b1;
                    phase = 2;
                end else k++;
            end
            @(negedge clk);
            lat++;
        end
        gnt_i    = 1'b0;
        rvalid_i = 1'b0;
        err_exp  = err_imm || timed_out;
        wen_exp  = !st && !err_exp && wen;
        rd_exp   = (!st && !err_exp) ? model_load(f3, maddr, rdata) : 32'h0;
        #1;
        checkOutput({tag, ".done_valid"}, valid_o, 1);
        checkOutput({tag, ".done_stall"}, stall_o, 0);
        checkOutput({tag, ".done_err"}, err_o, err_exp);
        checkOutput({tag, ".done_req"}, req_o, 0);
        checkOutput({tag, ".done_wen"}, regs_wen_o, wen_exp);
        checkOutput({tag, ".done_rd_data"}, rd_data_o, rd_exp);
        checkOutput({tag, ".done_inst"}, inst_o, inst);
        checkOutput({tag, ".done_iaddr"}, instaddr_o, iaddr_of(maddr));
        checkOutput({tag, ".done_rd_addr"}, rd_addr_o, rda);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput({tag, ".idle_valid"}, valid_o, 0);
        checkOutput({tag, ".idle_stall"}, stall_o, 0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [2:0] f3;
        logic st;
        logic [6:0] opcs [4];
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1101111};

        $display("[TB] start");
        applyStimulus(1'b1, mk_inst(7'b0000011, 3'b010, 5'd4), 32'h100, 32'h0, 1'b1, 5'd4, 32'h0);
        #1;
        checkOutput("rst.stall", stall_o, 0);
        checkOutput("rst.valid", valid_o, 0);
        checkOutput("rst.req", req_o, 0);
        checkOutput("rst.be", be_o, 0);
        checkOutput("rst.we", we_o, 0);
        checkOutput("rst.err", err_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        do_pass("add", 1'b1, mk_inst(7'b0110011, 3'b000, 5'd1), 32'h0000_1234, 1'b1, 5'd1);
        do_pass("novalid", 1'b0, mk_inst(7'b0010011, 3'b000, 5'd7), 32'hCAFE_0001, 1'b1, 5'd7);

        do_access("lb103", mk_inst(7'b0000011, 3'b000, 5'd5), 32'h103, 32'h0,
                  64'h0000_0000_80FF_0000, 1'b1, 5'd5, 0, 0, lat);
        checkOutput("lb103.latency", 64'(lat), 3);

        do_access("sh106", mk_inst(7'b0100011, 3'b001, 5'd0), 32'h106, 32'h0000_BEEF,
                  64'h0, 1'b1, 5'd0, 0, 1, lat);
        do_access("gnt_wait", mk_inst(7'b0100011, 3'b010, 5'd0), 32'h108, 32'h1357_9BDF,
                  64'h0, 1'b0, 5'd0, 4, 0, lat);
        do_access("timeout", mk_inst(7'b0000011, 3'b010, 5'd9), 32'h200, 32'h0,
                  64'h1111_2222_3333_4444, 1'b1, 5'd9, 0, 1000, lat);
        checkOutput("timeout.latency", 64'(lat), 17);
        do_access("lw102", mk_inst(7'b0000011, 3'b010, 5'd6), 32'h102, 32'h0,
                  64'h8765_4321_0FED_CBA9, 1'b1, 5'd6, 1, 1, lat);
        do_access("bad_ld", mk_inst(7'b0000011, 3'b011, 5'd8), 32'h110, 32'h0,
                  64'h0, 1'b1, 5'd8, 0, 0, lat);
        checkOutput("bad_ld.latency", 64'(lat), 1);
        do_access("bad_st", mk_inst(7'b0100011, 3'b101, 5'd0), 32'h114, 32'h55AA_55AA,
                  64'h0, 1'b0, 5'd0, 0, 0, lat);

        applyStimulus(1'b1, mk_inst(7'b0000011, 3'b010, 5'd3), 32'h300, 32'h0, 1'b1, 5'd3, 32'h0);
        @(negedge clk);
        gnt_i = 1'b1;
        @(negedge clk);
        gnt_i = 1'b0;
        #1;
        checkOutput("rst_wait.stall_before", stall_o, 1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_wait.stall", stall_o, 0);
        checkOutput("rst_wait.req", req_o, 0);
        checkOutput("rst_wait.valid", valid_o, 0);
        @(negedge clk);
        rstn = 1'b1;
        valid_i = 1'b0;
        rvalid_i = 1'b1;
        #1;
        checkOutput("rst_wait.no_done", valid_o, 0);
        @(negedge clk);
        rvalid_i = 1'b0;
        #1;
        checkOutput("rst_wait.idle_stall", stall_o, 0);
        checkOutput("rst_wait.idle_valid", valid_o, 0);
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_pass("rnd_pass", 1'($urandom_range(0, 1)),
                        {$urandom_range(0, 32'h1FFFFFF), opcs[$urandom_range(0, 3)]},
                        $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end else begin
                st = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                do_access("rnd_ls", mk_inst(st ? 7'b0100011 : 7'b0000011, f3, 5'($urandom_range(1, 31))),
                          $urandom(), $urandom(), {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 31)), $urandom_range(0, 4), $urandom_range(0, 4), lat);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
